// File: rtl/merge_pass_sequencer_if.sv
// Launch/config and per-pass command bundle between the control logic,
// the multi-pass sequencer and the merger-tree datapath.
interface merge_pass_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned SIZE_WIDTH = 64,
    parameter int unsigned PASS_WIDTH = 8
);
    logic                  ap_start;
    logic                  ap_idle;
    logic                  ap_done;
    logic [SIZE_WIDTH-1:0] size;
    logic [PASS_WIDTH-1:0] num_pass;
    logic [ADDR_WIDTH-1:0] in_ptr;
    logic [ADDR_WIDTH-1:0] out_ptr;
    logic [ADDR_WIDTH-1:0] tmp_ptr;
    logic                  pass_start;
    logic                  pass_done;
    logic [ADDR_WIDTH-1:0] pass_src_addr;
    logic [ADDR_WIDTH-1:0] pass_dst_addr;
    logic [SIZE_WIDTH-1:0] pass_xfer_size;
    logic [SIZE_WIDTH-1:0] pass_run_len;
    logic [PASS_WIDTH-1:0] pass_idx;
    logic [63:0]           busy_cycles;

    // Environment side: issues launches and pass completions.
    modport master (
        output ap_start, size, num_pass, in_ptr, out_ptr, tmp_ptr, pass_done,
        input  ap_idle, ap_done, pass_start, pass_src_addr, pass_dst_addr,
               pass_xfer_size, pass_run_len, pass_idx, busy_cycles
    );

    // Sequencer side.
    modport slave (
        input  ap_start, size, num_pass, in_ptr, out_ptr, tmp_ptr, pass_done,
        output ap_idle, ap_done, pass_start, pass_src_addr, pass_dst_addr,
               pass_xfer_size, pass_run_len, pass_idx, busy_cycles
    );
endinterface

// File: rtl/merge_pass_sequencer.sv
// Multi-pass scheduler for the merger-tree sort kernel: turns one launch into
// num_pass pass commands, ping-ponging buffers so the last pass writes out_ptr.
module merge_pass_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned SIZE_WIDTH     = 64,
    parameter int unsigned PASS_WIDTH     = 8,
    parameter int unsigned LEAVES         = 16,
    parameter int unsigned INIT_RUN_BYTES = 64
) (
    input  logic                  ap_clk,
    input  logic                  areset,
    merge_pass_sequencer_if.slave bus
);
    localparam int unsigned RUN_SHIFT = $clog2(LEAVES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                state_q;
    logic                  ap_idle_q;
    logic                  ap_done_q;
    logic                  pass_start_q;
    logic [SIZE_WIDTH-1:0] size_cfg_q;
    logic [PASS_WIDTH-1:0] np_cfg_q;
    logic [ADDR_WIDTH-1:0] in_cfg_q;
    logic [ADDR_WIDTH-1:0] out_cfg_q;
    logic [ADDR_WIDTH-1:0] tmp_cfg_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [SIZE_WIDTH-1:0] xfer_q;
    logic [SIZE_WIDTH-1:0] run_q;
    logic [PASS_WIDTH-1:0] idx_q;
    logic [63:0]           cnt_q;
    logic [63:0]           busy_q;

    logic [PASS_WIDTH-1:0] rem_first_d;
    logic [PASS_WIDTH-1:0] rem_next_d;
    logic [ADDR_WIDTH-1:0] dst_first_d;
    logic [ADDR_WIDTH-1:0] dst_next_d;
    logic [SIZE_WIDTH-1:0] run_first_d;
    logic [SIZE_WIDTH-1:0] run_next_d;
    logic                  last_pass_d;

    // Destination parity, saturating run growth and last-pass detection.
    always_comb begin
        rem_first_d = np_cfg_q - PASS_WIDTH'(1);
        rem_next_d  = np_cfg_q - PASS_WIDTH'(2) - idx_q;
        dst_first_d = rem_first_d[0] ? tmp_cfg_q : out_cfg_q;
        dst_next_d  = rem_next_d[0] ? tmp_cfg_q : out_cfg_q;
        run_first_d = (size_cfg_q < SIZE_WIDTH'(INIT_RUN_BYTES)) ? size_cfg_q
                                                                 : SIZE_WIDTH'(INIT_RUN_BYTES);
        // Saturate before shifting so the run length can never wrap.
        run_next_d  = (run_q > (size_cfg_q >> RUN_SHIFT)) ? size_cfg_q : (run_q << RUN_SHIFT);
        last_pass_d = (idx_q == rem_first_d);
    end

    // Sequencer state machine with registered outputs.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            ap_idle_q    <= 1'b1;
            ap_done_q    <= 1'b0;
            pass_start_q <= 1'b0;
            size_cfg_q   <= '0;
            np_cfg_q     <= '0;
            in_cfg_q     <= '0;
            out_cfg_q    <= '0;
            tmp_cfg_q    <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            xfer_q       <= '0;
            run_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= '0;
        end else begin
            pass_start_q <= 1'b0;
            ap_done_q    <= 1'b0;
            cnt_q        <= cnt_q + 64'd1;
            case (state_q)
                S_IDLE: begin
                    cnt_q     <= cnt_q;
                    ap_idle_q <= 1'b1;
                    if (bus.ap_start) begin
                        size_cfg_q <= bus.size;
                        np_cfg_q   <= bus.num_pass;
                        in_cfg_q   <= bus.in_ptr;
                        out_cfg_q  <= bus.out_ptr;
                        tmp_cfg_q  <= bus.tmp_ptr;
                        cnt_q      <= 64'd1;
                        ap_idle_q  <= 1'b0;
                        if (bus.size == '0 || bus.num_pass == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    idx_q        <= '0;
                    src_q        <= in_cfg_q;
                    dst_q        <= dst_first_d;
                    run_q        <= run_first_d;
                    xfer_q       <= size_cfg_q;
                    pass_start_q <= 1'b1;
                    state_q      <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.pass_done) begin
                        if (last_pass_d) begin
                            ap_done_q <= 1'b1;
                            busy_q    <= cnt_q + 64'd1;
                            state_q   <= S_DONE;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    idx_q        <= idx_q + PASS_WIDTH'(1);
                    src_q        <= dst_q;
                    dst_q        <= dst_next_d;
                    run_q        <= run_next_d;
                    pass_start_q <= 1'b1;
                    state_q      <= S_LAUNCH;
                end
                S_DONE: begin
                    // Pass path arrives with ap_done already raised; zero-work path raises it here.
                    if (ap_done_q) begin
                        ap_idle_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        ap_done_q <= 1'b1;
                        busy_q    <= cnt_q + 64'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ap_idle        = ap_idle_q;
    assign bus.ap_done        = ap_done_q;
    assign bus.pass_start     = pass_start_q;
    assign bus.pass_src_addr  = src_q;
    assign bus.pass_dst_addr  = dst_q;
    assign bus.pass_xfer_size = xfer_q;
    assign bus.pass_run_len   = run_q;
    assign bus.pass_idx       = idx_q;
    assign bus.busy_cycles    = busy_q;
endmodule

// File: tb/tb_merge_pass_sequencer.sv
// Directed and randomized bench for merge_pass_sequencer with a schedule-level
// reference model of pass commands, ping-pong buffers and launch/done timing.
module tb_merge_pass_sequencer;
    localparam int unsigned AW  = 64;
    localparam int unsigned SW  = 64;
    localparam int unsigned PW  = 8;
    localparam int unsigned LV  = 16;
    localparam int unsigned IRB = 64;

    logic ap_clk = 1'b0;
    logic areset;
    int   total = 0;
    int   bad   = 0;

    merge_pass_sequencer_if #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .PASS_WIDTH(PW)) bus ();

    merge_pass_sequencer #(
        .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .PASS_WIDTH(PW),
        .LEAVES(LV), .INIT_RUN_BYTES(IRB)
    ) dut (
        .ap_clk (ap_clk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Run length of pass k: INIT * LEAVES^k, clipped to the job size.
    function automatic logic [63:0] m_run(input logic [63:0] sz, input int k);
        logic [127:0] r;
        r = 128'(IRB);
        for (int i = 0; i < k; i++) begin
            if (r >= 128'(sz)) break;
            r = r * 128'(LV);
        end
        if (r > 128'(sz)) r = 128'(sz);
        return r[63:0];
    endfunction

    // Pass k writes out when an even number of passes remain after it.
    function automatic logic [63:0] m_dst(input int np, input int k,
                                          input logic [63:0] op, input logic [63:0] tp);
        return (((np - 1 - k) % 2) == 0) ? op : tp;
    endfunction

    function automatic logic [63:0] m_src(input int np, input int k, input logic [63:0] ip,
                                          input logic [63:0] op, input logic [63:0] tp);
        return (k == 0) ? ip : m_dst(np, k - 1, op, tp);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, ".idle"},  64'(bus.ap_idle), 64'd1);
        chk({tag, ".done"},  64'(bus.ap_done), 64'd0);
        chk({tag, ".pstart"}, 64'(bus.pass_start), 64'd0);
        chk({tag, ".src"},   bus.pass_src_addr, 64'd0);
        chk({tag, ".dst"},   bus.pass_dst_addr, 64'd0);
        chk({tag, ".xfer"},  bus.pass_xfer_size, 64'd0);
        chk({tag, ".run"},   bus.pass_run_len, 64'd0);
        chk({tag, ".idx"},   64'(bus.pass_idx), 64'd0);
        chk({tag, ".busy"},  bus.busy_cycles, 64'd0);
    endtask

    // One job: launch in cycle 0, answer each pass_start after a delay, check every cycle.
    task automatic run_job(input string name, input logic [63:0] sz, input int np,
                           input logic [63:0] ip, input logic [63:0] op, input logic [63:0] tp,
                           input int fix_dly, input bit spur, input int abort_pass);
        int starts[$];
        int dones[$];
        int n;
        int c;
        int d;
        int done_c;
        int k;
        bit ps_exp;
        n = (sz == 64'd0 || np == 0) ? 0 : np;
        c = 2;
        for (int i = 0; i < n; i++) begin
            d = (fix_dly > 0) ? fix_dly : int'($urandom_range(2, 12));
            starts.push_back(c);
            dones.push_back(c + d);
            c = c + d + 2;
        end
        done_c = (n == 0) ? 2 : dones[n - 1] + 1;

        bus.size     = sz;
        bus.num_pass = PW'(np);
        bus.in_ptr   = ip;
        bus.out_ptr  = op;
        bus.tmp_ptr  = tp;
        bus.ap_start = 1'b1;
        step();
        bus.ap_start = 1'b0;

        for (int cyc = 1; cyc <= done_c + 1; cyc++) begin
            k = -1;
            for (int i = 0; i < n; i++) begin
                if (starts[i] <= cyc) k = i;
            end
            ps_exp = (k >= 0) && (starts[k] == cyc);
            chk({name, ".pass_start"}, 64'(bus.pass_start), 64'(ps_exp));
            chk({name, ".ap_done"}, 64'(bus.ap_done), 64'(cyc == done_c));
            chk({name, ".ap_idle"}, 64'(bus.ap_idle), 64'(cyc > done_c));
            if (k >= 0 && cyc <= dones[k]) begin
                chk({name, ".src"},  bus.pass_src_addr, m_src(np, k, ip, op, tp));
                chk({name, ".dst"},  bus.pass_dst_addr, m_dst(np, k, op, tp));
                chk({name, ".run"},  bus.pass_run_len, m_run(sz, k));
                chk({name, ".idx"},  64'(bus.pass_idx), 64'(k));
                chk({name, ".xfer"}, bus.pass_xfer_size, sz);
            end
            if (cyc == done_c) begin
                chk({name, ".busy"}, bus.busy_cycles, 64'(done_c));
            end

            bus.pass_done = (k >= 0) && ((cyc == dones[k]) || (spur && cyc == starts[k]));
            if (spur && k >= 0 && cyc == starts[k] + 1) begin
                bus.ap_start = 1'b1;
                bus.in_ptr   = ~ip;
                bus.out_ptr  = ~op;
                bus.tmp_ptr  = ~tp;
                bus.size     = sz >> 1;
                bus.num_pass = PW'(np + 1);
            end
            if (abort_pass >= 0 && k == abort_pass && cyc == starts[k] + 1) begin
                areset        = 1'b1;
                bus.pass_done = 1'b0;
                step();
                areset = 1'b0;
                chk_reset({name, ".rst"});
                for (int j = 0; j < 6; j++) begin
                    step();
                    chk({name, ".post_rst_pstart"}, 64'(bus.pass_start), 64'd0);
                    chk({name, ".post_rst_done"}, 64'(bus.ap_done), 64'd0);
                end
                return;
            end
            step();
            bus.ap_start  = 1'b0;
            bus.pass_done = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] rs;
        logic [63:0] ri;
        logic [63:0] ro;
        logic [63:0] rt;
        int          rn;

        areset        = 1'b1;
        bus.ap_start  = 1'b0;
        bus.pass_done = 1'b0;
        bus.size      = '0;
        bus.num_pass  = '0;
        bus.in_ptr    = '0;
        bus.out_ptr   = '0;
        bus.tmp_ptr   = '0;
        repeat (3) step();
        chk_reset("por");
        areset = 1'b0;
        step();
        chk_reset("por_rel");

        // Stray pass_done while idle does nothing.
        bus.pass_done = 1'b1;
        step();
        bus.pass_done = 1'b0;
        chk("idle_pd.idle", 64'(bus.ap_idle), 64'd1);
        chk("idle_pd.pstart", 64'(bus.pass_start), 64'd0);
        step();
        chk("idle_pd.pstart2", 64'(bus.pass_start), 64'd0);
        chk("idle_pd.done", 64'(bus.ap_done), 64'd0);

        run_job("basic3", 64'h100000, 3, 64'h1000, 64'h2000, 64'h3000, 10, 1'b0, -1);
        run_job("zero_np", 64'h100000, 0, 64'h1000, 64'h2000, 64'h3000, 0, 1'b0, -1);
        run_job("zero_sz", 64'h0, 3, 64'h1000, 64'h2000, 64'h3000, 0, 1'b0, -1);
        run_job("sat4", 64'd2048, 4, 64'h1000, 64'h2000, 64'h3000, 0, 1'b0, -1);
        run_job("two_pass", 64'd4096, 2, 64'h1000, 64'h2000, 64'h3000, 0, 1'b0, -1);
        run_job("small_sz", 64'd40, 2, 64'h40, 64'h80, 64'hC0, 3, 1'b0, -1);
        run_job("huge", 64'hFFFF_FFFF_FFFF_FFFF, 20, 64'hA000, 64'hB000, 64'hC000, 2, 1'b0, -1);
        run_job("spurious", 64'h100000, 3, 64'h1000, 64'h2000, 64'h3000, 0, 1'b1, -1);
        run_job("midrst", 64'h100000, 3, 64'h1000, 64'h2000, 64'h3000, 0, 1'b0, 1);
        run_job("after_rst", 64'h100000, 3, 64'h5000, 64'h6000, 64'h7000, 0, 1'b0, -1);
        run_job("timing", 64'd512, 1, 64'h1000, 64'h2000, 64'h3000, 5, 1'b0, -1);

        for (int j = 0; j < 8; j++) begin
            rs = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 60);
            ri = {32'($urandom), 32'($urandom)};
            ro = {32'($urandom), 32'($urandom)};
            rt = {32'($urandom), 32'($urandom)};
            rn = int'($urandom_range(1, 6));
            run_job("rand", rs, rn, ri, ro, rt, 0, 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
